algn_md_rx_arbiter: RTL and testbench
=====================================

Name: algn_md_rx_arbiter

Overview:
- Shares the aligner's single MD RX slave port between NUM_REQ independent MD masters.
- Uses round-robin arbitration and holds the grant for exactly one transfer.
- Optionally rejects illegal offset/size combinations locally, so they never reach the aligner.
- Sits directly in front of the aligner's md_rx interface inside the aligner subsystem.

Parameters:
- ALGN_DATA_WIDTH, 32, MD data width in bits; power of two, at least 8. Derived localparams: BYTES_W = ALGN_DATA_WIDTH/8; OW = 1 if ALGN_DATA_WIDTH<=8 else clog2(BYTES_W); SW = clog2(BYTES_W)+1.
- NUM_REQ, 2, number of requesters, 2..4. IW = clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester MD valid.
- req_data  in  NUM_REQ*ALGN_DATA_WIDTH  per-requester data; slice i at [i*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH].
- req_offset  in  NUM_REQ*OW  per-requester byte offset.
- req_size  in  NUM_REQ*SW  per-requester byte count.
- req_ready  out  NUM_REQ  per-requester transfer complete.
- req_err  out  NUM_REQ  per-requester error response, valid only with req_ready.
- md_rx_valid  out  1  to aligner.
- md_rx_data  out  ALGN_DATA_WIDTH  to aligner.
- md_rx_offset  out  OW  to aligner.
- md_rx_size  out  SW  to aligner.
- md_rx_ready  in  1  from aligner.
- md_rx_err  in  1  from aligner.
- grant_id  out  IW  index of the current/last granted requester.
- busy  out  1  high in FWD or LERR.

Behaviour:
- MD protocol: a master holds valid, data, offset and size stable until it sees ready. The transfer completes on the cycle where valid & ready are both high. err is sampled only on that cycle.
- State register: IDLE, FWD, LERR. Round-robin pointer rr_ptr (IW bits). Grant register g.
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, g=0. All outputs 0: md_rx_* zero, req_ready=0, req_err=0, grant_id=0, busy=0. Reset mid-FWD drops md_rx_valid immediately; the in-flight transfer is lost and no ready is returned.
- IDLE:
  - If any req_valid is high, g <= first i with req_valid[i], searching from rr_ptr upward with wrap at NUM_REQ.
  - Next state is LERR if the local check is enabled and legal(g)=0; otherwise FWD.
  - No valid: stay in IDLE.
- legal(offset, size) is 1 only when all of the following hold:
  - 1 <= size <= BYTES_W;
  - offset < BYTES_W;
  - (BYTES_W + offset) % size == 0.
- FWD:
  - md_rx_valid = req_valid[g]. md_rx_data/offset/size = slice g, combinational mux; zero when not in FWD.
  - On md_rx_ready & md_rx_valid: req_ready[g]=1 and req_err[g]=md_rx_err in the same cycle (combinational). Next cycle: IDLE, rr_ptr <= (g+1) mod NUM_REQ.
  - md_rx_ready with req_valid[g]=0 is ignored.
  - If req_valid[g] drops before ready (protocol violation): abort to IDLE, rr_ptr advances, no ready is returned.
- LERR (one cycle): req_ready[g]=1, req_err[g]=1; md_rx_valid stays 0. Then IDLE, rr_ptr <= (g+1) mod NUM_REQ.
- Latency: request visible at edge k → md_rx_valid high after edge k+1. Each transfer costs at least one IDLE cycle, so peak rate is 1 transfer per 2 cycles.
- Non-granted requesters always see req_ready=0 and req_err=0.
- Simultaneous requests: rr_ptr decides. A new request from the just-served requester arriving in its ready cycle waits behind any other pending requesters.
- grant_id = g, registered; holds its value in IDLE. busy = (state != IDLE).

Optional Feature:
- Macro ALGN_ARB_LOCAL_CHECK_EN.
- Defined: the legal() check is applied in IDLE, and illegal requests go through LERR without touching md_rx.
- Undefined: LERR is unreachable; every request goes to FWD and errors come only from md_rx_err.

Test Plan:
- Single request, req0: offset=0, size=4, data=32'hAABBCCDD; aligner ready after 2 cycles with err=0. Expect md_rx_valid one cycle after req_valid, md_rx_data=32'hAABBCCDD, req_ready[0] pulse with req_err[0]=0, then IDLE.
- req0 and req1 both valid every cycle, each for 4 transfers, ready immediate. Expect grant order 0,1,0,1,0,1,0,1 with one IDLE cycle between grants.
- Macro defined, req1: offset=1, size=2 ((4+1)%2=1). Expect LERR: req_ready[1]=1 and req_err[1]=1 for one cycle, md_rx_valid never asserts. Repeat with size=0 and with offset=0, size=3: both rejected the same way.
- Macro undefined: same illegal request is forwarded; aligner returns err=1. Expect req_err[1]=1 with req_ready[1].
- Legal sweep: (offset,size) = (0,1), (1,1), (2,2), (3,1), (0,4). Expect all forwarded with fields passed through unchanged.
- reset_n low mid-FWD with md_rx_ready=0. Expect md_rx_valid=0 immediately and all outputs 0; after release, the first grant goes to req0 even if req1 was pending.

Source files
------------

// File: rtl/algn_md_rx_arbiter.sv
// -----------------------------------------------------------------------------
// algn_md_rx_arbiter
//
// Shares the aligner's single MD RX slave port between NUM_REQ independent MD
// masters. Round-robin arbitration, the grant is held for exactly one transfer
// and every transfer is followed by at least one IDLE cycle.
//
// Optional build macro: ALGN_ARB_LOCAL_CHECK_EN
//   defined   : illegal offset/size combinations are answered locally with an
//               error (one-cycle LERR state) and never reach the aligner.
//   undefined : every request is forwarded; errors come only from md_rx_err.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   req_valid/data/
//   req_offset/size     per-requester MD request, slice i of each packed bus
//   req_ready/req_err   per-requester completion and error (err valid with ready)
//   md_rx_*             MD master towards the aligner (valid/data/offset/size
//                       out, ready/err in)
//   grant_id            index of the current or most recently granted requester
//   busy                high while a grant is active (FWD or LERR)
// -----------------------------------------------------------------------------
module algn_md_rx_arbiter #(
    parameter  int unsigned ALGN_DATA_WIDTH = 32,
    parameter  int unsigned NUM_REQ         = 2,
    localparam int unsigned BYTES_W         = ALGN_DATA_WIDTH / 8,
    localparam int unsigned OW              = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES_W),
    localparam int unsigned SW              = $clog2(BYTES_W) + 1,
    localparam int unsigned IW              = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset_n,

    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*OW-1:0]           req_offset,
    input  logic [NUM_REQ*SW-1:0]           req_size,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_err,

    output logic                            md_rx_valid,
    output logic [ALGN_DATA_WIDTH-1:0]      md_rx_data,
    output logic [OW-1:0]                   md_rx_offset,
    output logic [SW-1:0]                   md_rx_size,
    input  logic                            md_rx_ready,
    input  logic                            md_rx_err,

    output logic [IW-1:0]                   grant_id,
    output logic                            busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_LERR
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] g_q, g_d;

    logic [ALGN_DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [OW-1:0]              off_arr  [NUM_REQ];
    logic [SW-1:0]              size_arr [NUM_REQ];

    logic [IW-1:0] pick;

    // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (32'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // First requester with valid set, searching upward from ptr with wrap.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [IW-1:0]      ptr);
        logic [IW-1:0] idx;
        logic [IW-1:0] res;
        logic          found;
        idx   = ptr;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && v[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return res;
    endfunction

`ifdef ALGN_ARB_LOCAL_CHECK_EN
    // A transfer is legal when 1 <= size <= BYTES_W, offset < BYTES_W and the
    // size evenly divides BYTES_W + offset.
    function automatic logic is_legal(input logic [OW-1:0] off,
                                      input logic [SW-1:0] sz);
        int unsigned s;
        int unsigned o;
        s = 32'(sz);
        o = 32'(off);
        if (s == 0 || s > BYTES_W || o >= BYTES_W) begin
            return 1'b0;
        end
        return ((BYTES_W + o) % s) == 0;
    endfunction
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
            off_arr[i]  = req_offset[i*OW +: OW];
            size_arr[i] = req_size[i*SW +: SW];
        end
    end

    assign pick = rr_pick(req_valid, rr_ptr_q);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        g_d          = g_q;
        md_rx_valid  = 1'b0;
        md_rx_data   = '0;
        md_rx_offset = '0;
        md_rx_size   = '0;
        req_ready    = '0;
        req_err      = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    g_d = pick;
`ifdef ALGN_ARB_LOCAL_CHECK_EN
                    state_d = is_legal(off_arr[pick], size_arr[pick]) ? ST_FWD : ST_LERR;
`else
                    state_d = ST_FWD;
`endif
                end
            end

            ST_FWD: begin
                md_rx_valid  = req_valid[g_q];
                md_rx_data   = data_arr[g_q];
                md_rx_offset = off_arr[g_q];
                md_rx_size   = size_arr[g_q];
                if (!req_valid[g_q]) begin
                    // Master withdrew its request: abandon silently.
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(g_q);
                end else if (md_rx_ready) begin
                    req_ready[g_q] = 1'b1;
                    req_err[g_q]   = md_rx_err;
                    state_d        = ST_IDLE;
                    rr_ptr_d       = next_idx(g_q);
                end
            end

            ST_LERR: begin
                req_ready[g_q] = 1'b1;
                req_err[g_q]   = 1'b1;
                state_d        = ST_IDLE;
                rr_ptr_d       = next_idx(g_q);
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
        end
    end

    assign grant_id = g_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_algn_md_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_algn_md_rx_arbiter
//
// Self-checking bench for algn_md_rx_arbiter (ALGN_DATA_WIDTH=32, NUM_REQ=2).
// Directed scenarios followed by a randomized phase checked against a
// transaction-level model (pending set + round-robin pointer). Honours the
// ALGN_ARB_LOCAL_CHECK_EN macro for its expectations.
// -----------------------------------------------------------------------------
module tb_algn_md_rx_arbiter;

`ifdef ALGN_ARB_LOCAL_CHECK_EN
    localparam bit LOCAL = 1'b1;
`else
    localparam bit LOCAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_offset;
    logic [5:0]  req_size;
    logic [1:0]  req_ready;
    logic [1:0]  req_err;
    logic        md_rx_valid;
    logic [31:0] md_rx_data;
    logic [1:0]  md_rx_offset;
    logic [2:0]  md_rx_size;
    logic        md_rx_ready;
    logic        md_rx_err;
    logic        grant_id;
    logic        busy;

    logic [31:0] t_data [2];
    logic [1:0]  t_off  [2];
    logic [2:0]  t_size [2];

    assign req_data   = {t_data[1], t_data[0]};
    assign req_offset = {t_off[1], t_off[0]};
    assign req_size   = {t_size[1], t_size[0]};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    algn_md_rx_arbiter #(
        .ALGN_DATA_WIDTH(32),
        .NUM_REQ        (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_offset  (req_offset),
        .req_size    (req_size),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .md_rx_valid (md_rx_valid),
        .md_rx_data  (md_rx_data),
        .md_rx_offset(md_rx_offset),
        .md_rx_size  (md_rx_size),
        .md_rx_ready (md_rx_ready),
        .md_rx_err   (md_rx_err),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int o, input int s);
        return (s >= 1) && (s <= 4) && (o < 4) && (((4 + o) % s) == 0);
    endfunction

    function automatic int rr_model(input logic [1:0] v, input int ptr);
        for (int k = 0; k < 2; k++) begin
            if (v[(ptr + k) % 2]) return (ptr + k) % 2;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        req_valid   = '0;
        md_rx_ready = 1'b0;
        md_rx_err   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_data[i] = '0;
            t_off[i]  = '0;
            t_size[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated transfer from requester i; lat >= 1 cycles of md_rx_valid
    // before the aligner answers.
    task automatic xfer(input int i, input logic [31:0] d, input logic [1:0] off,
                        input logic [2:0] sz, input int lat, input bit aerr);
        bit exp_local;
        exp_local = LOCAL && !legal(int'(off), int'(sz));
        @(posedge clk); #1;
        t_data[i] = d; t_off[i] = off; t_size[i] = sz;
        req_valid[i] = 1'b1;
        @(negedge clk);
        check("x_idle_busy", 64'(busy), 0);
        check("x_idle_valid", 64'(md_rx_valid), 0);
        @(negedge clk);
        check("x_grant", 64'(grant_id), 64'(i));
        check("x_busy", 64'(busy), 1);
        if (exp_local) begin
            check("x_lerr_valid", 64'(md_rx_valid), 0);
            check("x_lerr_ready", 64'(req_ready), 64'(1 << i));
            check("x_lerr_err", 64'(req_err), 64'(1 << i));
        end else begin
            check("x_valid", 64'(md_rx_valid), 1);
            check("x_data", 64'(md_rx_data), 64'(d));
            check("x_off", 64'(md_rx_offset), 64'(off));
            check("x_size", 64'(md_rx_size), 64'(sz));
            check("x_wait_ready", 64'(req_ready), 0);
            repeat (lat - 1) begin
                @(negedge clk);
                check("x_wait_ready", 64'(req_ready), 0);
                check("x_hold_valid", 64'(md_rx_valid), 1);
            end
            @(posedge clk); #1;
            md_rx_ready = 1'b1;
            md_rx_err   = aerr;
            @(negedge clk);
            check("x_ready", 64'(req_ready), 64'(1 << i));
            check("x_err", 64'(req_err), 64'(aerr) << i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        md_rx_ready  = 1'b0;
        md_rx_err    = 1'b0;
        @(negedge clk);
        check("x_after_busy", 64'(busy), 0);
        check("x_after_valid", 64'(md_rx_valid), 0);
        check("x_after_ready", 64'(req_ready), 0);
    endtask

    task automatic new_txn(input int i);
        req_valid[i] = 1'b1;
        t_data[i]    = $urandom;
        t_off[i]     = 2'($urandom_range(0, 3));
        t_size[i]    = 3'($urandom_range(0, 4));
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 64'(md_rx_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_grant", 64'(grant_id), 0);
        check("rst_ready", 64'(req_ready), 0);

        // Single request, aligner answers after 2 cycles
        xfer(0, 32'hAABBCCDD, 2'd0, 3'd4, 2, 1'b0);

        // Two requesters continuously valid, immediate ready
        begin
            int cnt [2];
            bit dn  [2];
            int nxt, ncomp, last_cyc;
            do_reset();
            cnt[0] = 0; cnt[1] = 0; dn[0] = 0; dn[1] = 0;
            nxt = 0; ncomp = 0; last_cyc = 0;
            @(posedge clk); #1;
            md_rx_ready = 1'b1;
            for (int i = 0; i < 2; i++) begin
                t_data[i] = {16'(i), 16'd0}; t_off[i] = 2'd0; t_size[i] = 3'd4;
                req_valid[i] = 1'b1;
            end
            for (int cyc = 0; cyc < 40 && ncomp < 8; cyc++) begin
                if (cyc > 0) begin
                    @(posedge clk); #1;
                end
                for (int i = 0; i < 2; i++) begin
                    if (dn[i]) begin
                        dn[i] = 0;
                        if (cnt[i] < 4) t_data[i] = {16'(i), 16'(cnt[i])};
                        else req_valid[i] = 1'b0;
                    end
                end
                @(negedge clk);
                if (md_rx_valid) begin
                    check("rr_order", 64'(grant_id), 64'(nxt));
                    check("rr_data", 64'(md_rx_data), 64'({16'(nxt), 16'(cnt[nxt])}));
                    check("rr_ready", 64'(req_ready), 64'(1 << nxt));
                    if (ncomp > 0) check("rr_gap", 64'(cyc - last_cyc), 2);
                    last_cyc = cyc;
                    dn[nxt] = 1;
                    cnt[nxt]++;
                    nxt = 1 - nxt;
                    ncomp++;
                end
            end
            check("rr_count", 64'(ncomp), 8);
            @(posedge clk); #1;
            req_valid   = '0;
            md_rx_ready = 1'b0;
        end

        // Illegal combinations: LERR when checked locally, else aligner error
        xfer(1, 32'h11223344, 2'd1, 3'd2, 1, 1'b1);
        xfer(1, 32'h55667788, 2'd0, 3'd0, 1, 1'b1);
        xfer(1, 32'h99AABBCC, 2'd0, 3'd3, 1, 1'b1);

        // Legal sweep
        xfer(0, 32'h01020304, 2'd0, 3'd1, 1, 1'b0);
        xfer(0, 32'h05060708, 2'd1, 3'd1, 1, 1'b0);
        xfer(0, 32'h090A0B0C, 2'd2, 3'd2, 1, 1'b0);
        xfer(0, 32'h0D0E0F10, 2'd3, 3'd1, 1, 1'b0);
        xfer(0, 32'h11121314, 2'd0, 3'd4, 1, 1'b0);

        // Reset in the middle of a forward to req1 while req0 is pending
        @(posedge clk); #1;
        t_data[1] = 32'hDEADBEEF; t_off[1] = 2'd0; t_size[1] = 3'd4;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        t_data[0] = 32'hCAFEF00D; t_off[0] = 2'd0; t_size[0] = 3'd4;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("mr_pre_grant", 64'(grant_id), 1);
        check("mr_pre_valid", 64'(md_rx_valid), 1);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 64'(md_rx_valid), 0);
        check("mr_data", 64'(md_rx_data), 0);
        check("mr_busy", 64'(busy), 0);
        check("mr_grant", 64'(grant_id), 0);
        check("mr_ready", 64'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_first_grant", 64'(grant_id), 0);
        check("mr_first_busy", 64'(busy), 1);

        // Randomized phase against the transaction-level model
        begin
            bit         dn [2];
            bit         was_busy, done_last, g_local, exp_busy;
            logic [1:0] snap_prev, snap_cur;
            int         ptr, g;
            do_reset();
            dn[0] = 0; dn[1] = 0;
            was_busy = 0; done_last = 0; g_local = 0;
            snap_prev = '0; ptr = 0; g = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if (dn[i]) begin
                        dn[i] = 0;
                        req_valid[i] = 1'b0;
                        if ($urandom_range(0, 1) == 1) new_txn(i);
                    end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                        new_txn(i);
                    end
                end
                md_rx_ready = ($urandom_range(0, 2) == 0);
                md_rx_err   = ($urandom_range(0, 3) == 0);
                snap_cur    = req_valid;
                @(negedge clk);
                exp_busy = was_busy ? !done_last : (snap_prev != 2'b00);
                check("r_busy", 64'(busy), 64'(exp_busy));
                done_last = 0;
                if (busy && !was_busy) begin
                    g = rr_model(snap_prev, ptr);
                    if (g < 0) g = 0;
                    check("r_grant", 64'(grant_id), 64'(g));
                    g_local = LOCAL && !legal(int'(t_off[g]), int'(t_size[g]));
                end
                if (busy) begin
                    if (g_local) begin
                        check("r_lerr_valid", 64'(md_rx_valid), 0);
                        check("r_lerr_ready", 64'(req_ready), 64'(1 << g));
                        check("r_lerr_err", 64'(req_err), 64'(1 << g));
                        done_last = 1;
                    end else begin
                        check("r_valid", 64'(md_rx_valid), 1);
                        check("r_data", 64'(md_rx_data), 64'(t_data[g]));
                        check("r_off", 64'(md_rx_offset), 64'(t_off[g]));
                        check("r_size", 64'(md_rx_size), 64'(t_size[g]));
                        if (md_rx_ready) begin
                            check("r_ready", 64'(req_ready), 64'(1 << g));
                            check("r_err", 64'(req_err), 64'(md_rx_err) << g);
                            done_last = 1;
                        end else begin
                            check("r_noready", 64'(req_ready), 0);
                            check("r_noerr", 64'(req_err), 0);
                        end
                    end
                    if (done_last) begin
                        dn[g] = 1;
                        ptr = (g + 1) % 2;
                    end
                end else begin
                    check("r_idle_ready", 64'(req_ready), 0);
                    check("r_idle_err", 64'(req_err), 0);
                    check("r_idle_valid", 64'(md_rx_valid), 0);
                end
                was_busy  = busy;
                snap_prev = snap_cur;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
